// File: rtl/midi_btn_encoder.sv
// Button-press to MIDI note-on/note-off encoder: arbitrates pending presses and streams 3-byte messages.
// Define MIDI_RUNNING_STATUS_EN to omit the status byte when it matches the last one sent.
module midi_btn_encoder #(
  parameter int NUM_BTN   = 4,
  parameter int CHANNEL   = 0,
  parameter int BASE_NOTE = 60,
  parameter int VELOCITY  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raised,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overflow
);

  // state  | meaning
  // IDLE   | no message in flight; grants lowest pending button
  // STATUS | presenting 0x90|CHANNEL
  // NOTE   | presenting note number of latched button
  // VEL    | presenting velocity (note-on) or 0x00 (note-off)
  typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} state_t;

  localparam logic [7:0] STATUS_BYTE = 8'h90 | 8'(CHANNEL);

  state_t             state, state_nxt;
  logic [NUM_BTN-1:0] pending, note_on, grant;
  logic [2:0]         idx, idx_sel;
  logic               any_pend, vel_on;
  logic [7:0]         note_byte;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
`endif

  always_comb begin
    idx_sel  = '0;
    any_pend = 1'b0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx_sel  = 3'(i);
        any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    grant  = '0;
    vel_on = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      grant[i] = (state == IDLE) && any_pend && (idx_sel == 3'(i));
      if (idx == 3'(i)) vel_on = note_on[i];
    end
  end

  assign note_byte = (8'(BASE_NOTE) + {5'b0, idx}) & 8'h7F;

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: begin
        if (any_pend) begin
`ifdef MIDI_RUNNING_STATUS_EN
          state_nxt = (last_status == STATUS_BYTE) ? NOTE : STATUS;
`else
          state_nxt = STATUS;
`endif
        end
      end
      STATUS: begin
        tx_valid = 1'b1;
        tx_data  = STATUS_BYTE;
        if (tx_ready) state_nxt = NOTE;
      end
      NOTE: begin
        tx_valid = 1'b1;
        tx_data  = note_byte;
        if (tx_ready) state_nxt = VEL;
      end
      VEL: begin
        tx_valid = 1'b1;
        tx_data  = vel_on ? 8'(VELOCITY) : 8'h00;
        if (tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || (|pending);

  // A press colliding with its own grant stays pending; only an ungranted repeat is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= '0;
      note_on  <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= (pending & ~grant) | btn_raised;
      note_on  <= note_on ^ grant;
      overflow <= |(btn_raised & pending & ~grant);
      if ((state == IDLE) && any_pend) idx <= idx_sel;
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_status <= 8'h00;
    end else if ((state == STATUS) && tx_ready) begin
      last_status <= STATUS_BYTE;
    end
  end
`endif

endmodule
